// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants for the APB interrupt controller: register map and id width.
package apb_irq_ctrl_pkg;

    // Register indices, decoded from PADDR[4:2].
    localparam logic [2:0] IER = 3'd0;  // enable mask, RW
    localparam logic [2:0] IPR = 3'd1;  // pending, RO
    localparam logic [2:0] ISP = 3'd2;  // write-1-to-set pending
    localparam logic [2:0] ICP = 3'd3;  // write-1-to-clear pending
    localparam logic [2:0] ISR = 3'd4;  // pending & enable, RO
    localparam logic [2:0] IID = 3'd5;  // current id, RO

    // Width of an interrupt index (up to 32 sources).
    localparam int unsigned IRQ_ID_W = 5;

    // APB data bus width.
    localparam int unsigned APB_DATA_W = 32;

endpackage

// File: rtl/apb_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of the active vector.
// Bit 0 has the highest priority; id is 0 when nothing is active.
module irq_prio_enc
    import apb_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]  active,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    // Scan upward and keep the first hit only.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (active[i] && !valid) begin
                valid = 1'b1;
                id    = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge-latches level interrupt lines into a pending
// register, masks them with an enable register and presents the
// lowest-numbered active source to the core, which acknowledges by id.
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_IRQ        = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_IRQ-1:0]        irq_i,
    output logic                      irq_req_o,
    output logic [IRQ_ID_W-1:0]       irq_id_o,
    input  logic                      irq_ack_i,
    input  logic [IRQ_ID_W-1:0]       irq_ack_id_i
);

    logic [NUM_IRQ-1:0]  ier_q;
    logic [NUM_IRQ-1:0]  ipr_q;
    logic [NUM_IRQ-1:0]  irq_prev_q;

    logic                wr_en;
    logic                rd_en;
    logic [2:0]          reg_idx;
    logic [NUM_IRQ-1:0]  wdata_irq;

    logic [NUM_IRQ-1:0]  edge_set;
    logic [NUM_IRQ-1:0]  sw_set;
    logic [NUM_IRQ-1:0]  sw_clr;
    logic [NUM_IRQ-1:0]  ack_clr;
    logic [NUM_IRQ-1:0]  ipr_next;
    logic [NUM_IRQ-1:0]  active;

    logic                enc_valid;
    logic [IRQ_ID_W-1:0] enc_id;
    logic [31:0]         rdata;

    // Address/data bits outside the register map are not decoded.
    logic                unused_bus_bits;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign wr_en     = PSEL && PENABLE && PWRITE;
    assign rd_en     = PSEL && PENABLE && !PWRITE;
    assign reg_idx   = PADDR[4:2];
    assign wdata_irq = PWDATA[NUM_IRQ-1:0];

    assign unused_bus_bits = ^{PADDR, PWDATA};

    assign edge_set = irq_i & ~irq_prev_q;
    assign sw_set   = (wr_en && reg_idx == ISP) ? wdata_irq : '0;
    assign sw_clr   = (wr_en && reg_idx == ICP) ? wdata_irq : '0;

    // Decode the ack id into a one-hot clear mask; ids >= NUM_IRQ match nothing.
    always_comb begin
        ack_clr = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            ack_clr[k] = irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(k));
        end
    end

    // Clear first, then set, so a set event wins over a same-cycle clear.
    assign ipr_next = (ipr_q & ~(sw_clr | ack_clr)) | edge_set | sw_set;

    // Edge-detector history register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_i;
        end
    end

    // Pending register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ipr_q <= '0;
        end else begin
            ipr_q <= ipr_next;
        end
    end

    // Enable register, written through IER.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ier_q <= '0;
        end else if (wr_en && reg_idx == IER) begin
            ier_q <= wdata_irq;
        end
    end

    assign active = ipr_q & ier_q;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .active (active),
        .valid  (enc_valid),
        .id     (enc_id)
    );

    assign irq_req_o = enc_valid;
    assign irq_id_o  = enc_id;

    // Combinational read mux; idle bus and unmapped indices return 0.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_idx)
                IER:     rdata = 32'(ier_q);
                IPR:     rdata = 32'(ipr_q);
                ISR:     rdata = 32'(active);
                IID:     rdata = 32'(enc_id);
                default: rdata = '0;
            endcase
        end
    end

    assign PRDATA = rdata;

endmodule

// File: doc/apb_irq_ctrl.md
# apb_irq_ctrl

APB interrupt controller that consumes the level interrupt lines from the timer (overflow and compare) and other peripherals. It latches rising edges into a pending register, masks them with an enable register, and presents the lowest-numbered active source to the core. The core acknowledges with a request/ack handshake. It sits directly downstream of the timer on the same APB segment.

## Interface
- APB_ADDR_WIDTH, 12: APB address width (4 KB slave window).
- NUM_IRQ, 8: number of interrupt sources, 1..32.
- HCLK  in  1  clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address; register index = PADDR[4:2].
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PRDATA  out  32  APB read data; 0 when no read access.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- irq_i  in  NUM_IRQ  level interrupt sources; timer irq_o[1:0] connects to bits [1:0].
- irq_req_o  out  1  interrupt request to core.
- irq_id_o  out  5  index of the highest-priority enabled pending source.
- irq_ack_i  in  1  core acknowledge, one-cycle pulse.
- irq_ack_id_i  in  5  index being acknowledged.

## Operation
- Registers, index = PADDR[4:2]; bits above NUM_IRQ-1 read 0 and ignore writes:
  - 0 IER, RW: enable mask.
  - 1 IPR, RO: pending.
  - 2 ISP, W1S: write-1 sets pending (software trigger).
  - 3 ICP, W1C: write-1 clears pending.
  - 4 ISR, RO: IPR & IER.
  - 5 IID, RO: {27'b0, irq_id_o}.
  - 6–7: read 0, writes ignored.
- Writes take effect when PSEL && PENABLE && PWRITE. Reads are combinational when PSEL && PENABLE && !PWRITE.
- Edge detection:
  - irq_prev_q registers irq_i every cycle.
  - A set event for bit k is irq_i[k] && !irq_prev_q[k].
  - A source held high sets pending once only.
- Pending update each cycle, for each bit k, in this order:
  1. Clear if ICP write has bit k set, or if irq_ack_i && irq_ack_id_i == k.
  2. Set if edge event or ISP write has bit k set.
  - Set wins over clear in the same cycle.
- Arbitration is combinational from registered state:
  - active = IPR & IER.
  - irq_req_o = |active.
  - irq_id_o = index of lowest set bit of active (bit 0 highest priority); 0 when active == 0.
- An ack with irq_ack_id_i >= NUM_IRQ is ignored.
- An ack for a bit that is not pending is harmless.

## Timing
- Reset values: IER = 0, IPR = 0, irq_prev_q = 0. Outputs irq_req_o = 0, irq_id_o = 0, PRDATA = 0.
- Reset state with irq_i already high: irq_prev_q = 0, so the first cycle after reset release counts as a rising edge.
- Edge to request latency:
  - Rising edge of irq_i sampled at clock N → IPR bit set after edge N.
  - irq_req_o high in cycle N+1 if enabled.
- Software trigger: ISP write at edge N → irq_req_o high in cycle N+1.
- Ack: irq_ack_i at edge N → bit cleared after N. irq_req_o/irq_id_o update in cycle N+1 to the next source, or drop.
- Enabling a pending bit via IER raises irq_req_o the cycle after the write. Pending bits are never lost by masking.
- Timer compare pulses last one cycle; each pulse is latched. Back-to-back pulses separated by one low cycle produce two set events. Pulses arriving while the bit is already pending merge.
- Reset mid-operation clears all pending state immediately (asynchronous). irq_req_o is 0 while HRESET is high.

## Structure
- Package apb_irq_ctrl_pkg holds:
  - register index localparams: IER = 3'd0, IPR = 3'd1, ISP = 3'd2, ICP = 3'd3, ISR = 3'd4, IID = 3'd5;
  - IRQ_ID_W = 5.
- Sub-module irq_prio_enc is natural:
  - parameterised by NUM_IRQ;
  - input active vector;
  - outputs valid and id (lowest set bit);
  - purely combinational.
- Top level holds the edge detector, pending/enable flops, APB decode and read mux.

## Test plan
- Reset, then IER = 0x3; pulse irq_i[1] for 1 cycle → IPR = 0x2, irq_req_o = 1 and irq_id_o = 1 the next cycle; ack id 1 → irq_req_o = 0 the following cycle.
- IER = 0xFF; raise irq_i[5] and irq_i[2] in the same cycle → irq_id_o = 2; ack 2 → irq_id_o = 5; ack 5 → irq_req_o = 0.
- IER = 0; pulse irq_i[0] → IPR = 0x1, irq_req_o = 0; write IER = 0x1 → irq_req_o = 1 the next cycle; ISR reads 0x1.
- Hold irq_i[3] high for 10 cycles with IER = 0x8; ack once → pending stays 0 (no retrigger), irq_req_o = 0.
- In the same cycle: ICP write 0x1 and a rising edge on irq_i[0] → IPR bit 0 remains 1. ISP write 0x80 → irq_id_o = 7 when IER = 0x80.
- Set IPR = 0xFF via ISP, assert HRESET asynchronously mid-cycle → IPR = 0 and irq_req_o = 0 immediately; PRDATA of IID = 0 after reset.
